// File: rtl/bitty_instr_server.sv
// bitty_instr_server: UART request responder serving 16-bit words from a 256-word memory.
// Reads answer high byte then low byte; writes answer ACK_BYTE.
module bitty_instr_server #(
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  input  logic        tx_done,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  input  logic        ld_en,
  input  logic [7:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic        busy,
  output logic        err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_HI, GET_LO, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, SEND_ACK, WAIT_ACK
  } state_t;

  state_t        state, next;
  logic [15:0]   mem [256];
  logic [CW-1:0] cnt;
  logic [15:0]   shift;
  logic [7:0]    addr_q, hi_q;
  logic          wr_q, get, tmo, cmd_ok, err_d;

  assign get    = state inside {GET_ADDR, GET_HI, GET_LO};
  assign tmo    = get && !rx_done && cnt == CW'(TIMEOUT_CYCLES);
  assign cmd_ok = rx_data inside {8'h01, 8'h02, 8'h03};
  // Any byte outside IDLE/GET_* is an overrun; a bad first byte is a command error.
  assign err_d  = (rx_done && (state == IDLE ? !cmd_ok : !get)) || tmo;
  assign tx_en  = state inside {SEND_HI, SEND_LO, SEND_ACK};
  assign tx_data = shift[15:8];
  assign busy   = state != IDLE;

  always_comb begin
    next = state;
    case (state)
      IDLE:     next = rx_done && cmd_ok ? GET_ADDR : IDLE;
      GET_ADDR: next = rx_done ? (wr_q ? GET_HI : SEND_HI) : tmo ? IDLE : GET_ADDR;
      GET_HI:   next = rx_done ? GET_LO : tmo ? IDLE : GET_HI;
      GET_LO:   next = rx_done ? SEND_ACK : tmo ? IDLE : GET_LO;
      SEND_HI:  next = WAIT_HI;
      WAIT_HI:  next = tx_done ? SEND_LO : WAIT_HI;
      SEND_LO:  next = WAIT_LO;
      WAIT_LO:  next = tx_done ? IDLE : WAIT_LO;
      SEND_ACK: next = WAIT_ACK;
      WAIT_ACK: next = tx_done ? IDLE : WAIT_ACK;
      default:  next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      wr_q   <= 1'b0;
      addr_q <= 8'h00;
      hi_q   <= 8'h00;
      shift  <= 16'h0000;
      err    <= 1'b0;
    end else begin
      state <= next;
      err   <= err_d;
      cnt   <= (get && !rx_done && !tmo) ? cnt + 1'b1 : '0;
      if (state == IDLE && rx_done) wr_q <= rx_data == 8'h02;
      if (state == GET_ADDR && rx_done) addr_q <= rx_data;
      if (state == GET_HI && rx_done) hi_q <= rx_data;
      // The word is frozen here so later preloads cannot corrupt a response in flight.
      if (state == GET_ADDR && rx_done && !wr_q) shift <= mem[rx_data];
      else if (state == WAIT_HI && tx_done) shift <= {shift[7:0], 8'h00};
      else if (state == GET_LO && rx_done) shift <= {ACK_BYTE, 8'h00};
    end
  end

  // UART write is issued last so it wins an address collision with a preload.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (state == GET_LO && rx_done) mem[addr_q] <= {hi_q, rx_data};
  end
endmodule

// File: tb/tb_bitty_instr_server.sv
// tb_bitty_instr_server: scoreboard bench; stimulus queues expected tx bytes and err pulses,
// a monitor pops and compares whenever tx_en or err is seen.
module tb_bitty_instr_server;
  localparam logic [8:0] ERR = 9'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_done = 1'b0;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = 8'h00;
  logic [15:0] ld_data = 16'h0000;
  logic        busy, err;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] expq[$];

  bitty_instr_server #(.TIMEOUT_CYCLES(16), .ACK_BYTE(8'h06)) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
    .tx_done(tx_done), .tx_en(tx_en), .tx_data(tx_data),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200 && busy; i++) tick();
    tick();
    chk(name, {15'h0, busy}, 16'h0);
  endtask

  task automatic push_word(input logic [15:0] w);
    expq.push_back({1'b0, w[15:8]});
    expq.push_back({1'b0, w[7:0]});
  endtask

  // UART transmitter model: finishes each byte a few cycles after tx_en.
  initial begin
    tick();
    forever begin
      if (tx_en === 1'b1) begin
        repeat (5) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
      end else tick();
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(posedge clk);
      #2;
      if (tx_en === 1'b1) begin
        if (expq.size() == 0) chk("unexpected_tx", {8'h0, tx_data}, 16'hFFFF);
        else chk("tx_byte", {8'h0, tx_data}, {7'h0, expq.pop_front()});
      end
      if (err === 1'b1) begin
        if (expq.size() == 0) chk("unexpected_err", 16'h0100, 16'hFFFF);
        else chk("err_pulse", 16'h0100, {7'h0, expq.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    tick();
    chk("rst_tx_en", {15'h0, tx_en}, 16'h0);
    chk("rst_tx_data", {8'h0, tx_data}, 16'h0);
    chk("rst_busy", {15'h0, busy}, 16'h0);
    chk("rst_err", {15'h0, err}, 16'h0);
    reset = 1'b1;
    tick();
    preload(8'h10, 16'hA5C3);
    preload(8'h00, 16'h1357);
    preload(8'h40, 16'hBEEF);

    // Fetch with exact high-byte latency
    push_word(16'hA5C3);
    send(8'h03);
    chk("busy_rise", {15'h0, busy}, 16'h1);
    send(8'h10);
    chk("fetch_lat_tx_en", {15'h0, tx_en}, 16'h1);
    chk("fetch_lat_data", {8'h0, tx_data}, 16'h00A5);
    wait_idle("fetch_idle");

    // Write then data read
    expq.push_back(9'h006);
    send(8'h02); send(8'h20); send(8'h12); send(8'h34);
    chk("ack_tx_en", {15'h0, tx_en}, 16'h1);
    chk("ack_data", {8'h0, tx_data}, 16'h0006);
    wait_idle("write_idle");
    push_word(16'h1234);
    send(8'h01); send(8'h20);
    wait_idle("read_idle");

    // Bad command
    expq.push_back(ERR);
    send(8'h7F);
    chk("badcmd_busy", {15'h0, busy}, 16'h0);
    tick();
    chk("badcmd_busy2", {15'h0, busy}, 16'h0);
    push_word(16'h1357);
    send(8'h03); send(8'h00);
    wait_idle("after_bad_idle");

    // Timeout abandons the write
    expq.push_back(ERR);
    send(8'h02); send(8'h40); send(8'hAA);
    repeat (20) tick();
    chk("timeout_busy", {15'h0, busy}, 16'h0);
    chk("timeout_err_seen", 16'(expq.size()), 16'h0);
    push_word(16'hBEEF);
    send(8'h01); send(8'h40);
    wait_idle("timeout_read_idle");

    // Overrun during WAIT_HI with a same-address preload
    expq.push_back(9'h0A5);
    expq.push_back(ERR);
    expq.push_back(9'h0C3);
    send(8'h03); send(8'h10);
    tick(); tick();
    ld_en = 1'b1; ld_addr = 8'h10; ld_data = 16'hFFFF;
    send(8'h55);
    ld_en = 1'b0;
    wait_idle("overrun_idle");
    push_word(16'hFFFF);
    send(8'h03); send(8'h10);
    wait_idle("overrun_ld_idle");

    // UART write beats a same-address preload; a different-address preload still lands
    expq.push_back(9'h006);
    send(8'h02); send(8'h30); send(8'h11);
    ld_en = 1'b1; ld_addr = 8'h30; ld_data = 16'h9999;
    send(8'h22);
    ld_en = 1'b0;
    wait_idle("coll_idle");
    expq.push_back(9'h006);
    send(8'h02); send(8'h32); send(8'h44);
    ld_en = 1'b1; ld_addr = 8'h31; ld_data = 16'h7777;
    send(8'h55);
    ld_en = 1'b0;
    wait_idle("coll2_idle");
    push_word(16'h1122);
    send(8'h01); send(8'h30);
    wait_idle("coll_rd_idle");
    push_word(16'h7777);
    send(8'h01); send(8'h31);
    wait_idle("coll_rd2_idle");
    push_word(16'h4455);
    send(8'h01); send(8'h32);
    wait_idle("coll_rd3_idle");

    // Reset in GET_LO discards the write
    preload(8'h10, 16'hA5C3);
    send(8'h02); send(8'h10); send(8'h12);
    chk("pre_reset_busy", {15'h0, busy}, 16'h1);
    reset = 1'b0;
    #1;
    chk("reset_busy", {15'h0, busy}, 16'h0);
    chk("reset_tx_en", {15'h0, tx_en}, 16'h0);
    chk("reset_err", {15'h0, err}, 16'h0);
    tick(); tick();
    reset = 1'b1;
    tick();
    push_word(16'hA5C3);
    send(8'h03); send(8'h10);
    wait_idle("post_reset_idle");

    repeat (5) tick();
    chk("queue_empty", 16'(expq.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
